// File: rtl/line_cache_sched_pkg.sv
// Shared constants and types for the GBA line RAM scheduler
// and the HDMI image generator line caches.
package line_cache_sched_pkg;

    localparam int LINE_PXLS   = 240;
    localparam int FRAME_LINES = 160;
    localparam int SLOT_BITS   = 2;
    localparam int GBA_PXL_W   = 15;

    typedef enum logic [1:0] {
        PREV = 2'd0,
        CUR  = 2'd1,
        NEXT = 2'd2
    } cache_sel_t;

    typedef struct packed {
        logic       vld;
        cache_sel_t sel;
        logic [7:0] pxl;
    } rd_tag_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v,
                                           input logic [7:0] top);
        return (v >= top) ? top : v + 8'd1;
    endfunction

endpackage

// File: rtl/line_fetch_fsm.sv
// Burst reader for the prev/cur/next triplet: FSM, read pixel
// counter and the RAM read-return pipeline into the line caches.
module line_fetch_fsm import line_cache_sched_pkg::*; #(
    parameter int PXLS = LINE_PXLS,
    parameter int LAT  = 1
) (
    input  logic       pxlClk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       stall,
    output logic       rdEn,
    output cache_sel_t rdSel,
    output logic [7:0] rdPxl,
    output logic       busy,
    output logic       fetchDone,
    output logic       cacheWe,
    output logic [1:0] cacheSel,
    output logic [7:0] cacheAddr
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_PREV,
        FETCH_CUR,
        FETCH_NEXT,
        DRAIN
    } state_t;

    localparam logic [7:0] LAST      = 8'(PXLS - 1);
    localparam logic [1:0] DRAIN_END = 2'(LAT - 1);

    state_t     state;
    logic [7:0] pxl;
    logic [1:0] drainCnt;
    rd_tag_t    pipe [LAT];

    always_comb begin
        rdEn  = 1'b0;
        rdSel = PREV;
        unique case (state)
            FETCH_PREV: begin rdEn = ~stall; rdSel = PREV; end
            FETCH_CUR:  begin rdEn = ~stall; rdSel = CUR;  end
            FETCH_NEXT: begin rdEn = ~stall; rdSel = NEXT; end
            default: ;
        endcase
    end

    assign rdPxl     = pxl;
    assign cacheWe   = pipe[LAT-1].vld;
    assign cacheSel  = pipe[LAT-1].sel;
    assign cacheAddr = pipe[LAT-1].pxl;

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state     <= IDLE;
            pxl       <= 8'd0;
            drainCnt  <= 2'd0;
            busy      <= 1'b0;
            fetchDone <= 1'b0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            fetchDone <= 1'b0;
            pipe[0]   <= '{vld: rdEn, sel: rdSel, pxl: pxl};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (rdEn) pxl <= (pxl == LAST) ? 8'd0 : pxl + 8'd1;
            unique case (state)
                IDLE: if (start) begin
                    state <= FETCH_PREV;
                    busy  <= 1'b1;
                    pxl   <= 8'd0;
                end
                FETCH_PREV: if (rdEn && pxl == LAST) state <= FETCH_CUR;
                FETCH_CUR:  if (rdEn && pxl == LAST) state <= FETCH_NEXT;
                FETCH_NEXT: if (rdEn && pxl == LAST) begin
                    state    <= DRAIN;
                    drainCnt <= 2'd0;
                end
                DRAIN: if (drainCnt == DRAIN_END) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    fetchDone <= 1'b1;
                end else begin
                    drainCnt <= drainCnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
            // frame restart drops the fetch and anything still in flight
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                fetchDone <= 1'b0;
                pxl       <= 8'd0;
                for (int i = 0; i < LAT; i++) pipe[i].vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_cache_sched.sv
// Line RAM arbiter: GBA writer into a 4-slot ring with absolute
// priority, plus triplet fetch into the neighbourhood line caches.
module line_cache_sched #(
    parameter int LINE_PXLS   = 240,
    parameter int FRAME_LINES = 160,
    parameter int SLOT_BITS   = 2,
    parameter int PXL_W       = 15,
    parameter int RD_LAT      = 1
) (
    input  logic                 pxlClk,
    input  logic                 rst,
    input  logic                 newFrameIn,
    input  logic                 wrValid,
    input  logic [PXL_W-1:0]     wrData,
    input  logic                 wrLineEnd,
    input  logic                 lineAdvance,
    input  logic                 fetchStart,
    output logic                 ramEn,
    output logic                 ramWe,
    output logic [SLOT_BITS+7:0] ramAddr,
    output logic [PXL_W-1:0]     ramWrData,
    input  logic [PXL_W-1:0]     ramRdData,
    output logic                 cacheWe,
    output logic [1:0]           cacheSel,
    output logic [7:0]           cacheAddr,
    output logic [PXL_W-1:0]     cacheData,
    output logic                 busy,
    output logic                 fetchDone,
    output logic                 overrun,
    output logic                 underrun,
    output logic [7:0]           rdLine
);
    import line_cache_sched_pkg::*;

    localparam logic [7:0] LAST_PXL  = 8'(LINE_PXLS - 1);
    localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);
    localparam logic [7:0] MAX_LINES = 8'(FRAME_LINES);

    logic                 nfQ, nfRise, start;
    logic [SLOT_BITS-1:0] wrSlot, prvSlot, rdSlot;
    logic [7:0]           wrPxl, wrLines, nxtLine;
    logic                 nxtMissing, hitSrc;
    logic [SLOT_BITS-1:0] srcSlot [3];
    logic                 rdEn;
    cache_sel_t           rdSel;
    logic [7:0]           rdPxl;

    assign nfRise = newFrameIn & ~nfQ;
    assign start  = fetchStart & ~busy & ~nfRise;

    assign prvSlot    = (rdLine == 8'd0) ? '0
                      : rdLine[SLOT_BITS-1:0] - SLOT_BITS'(1);
    assign nxtLine    = sat_inc(rdLine, LAST_LINE);
    assign nxtMissing = nxtLine >= wrLines;

    assign hitSrc = (wrSlot == srcSlot[0])
                  | (wrSlot == srcSlot[1])
                  | (wrSlot == srcSlot[2]);

    always_comb begin
        rdSlot = srcSlot[2];
        unique case (rdSel)
            PREV:    rdSlot = srcSlot[0];
            CUR:     rdSlot = srcSlot[1];
            default: rdSlot = srcSlot[2];
        endcase
    end

    always_comb begin
        ramEn     = wrValid | rdEn;
        ramWe     = wrValid;
        ramWrData = wrData;
        ramAddr   = wrValid ? {wrSlot, wrPxl} : {rdSlot, rdPxl};
    end

    assign cacheData = ramRdData;

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            nfQ      <= 1'b0;
            wrSlot   <= '0;
            wrPxl    <= 8'd0;
            wrLines  <= 8'd0;
            rdLine   <= 8'd0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            for (int i = 0; i < 3; i++) srcSlot[i] <= '0;
        end else begin
            nfQ <= newFrameIn;
            if (wrValid)
                wrPxl <= (wrPxl == LAST_PXL) ? wrPxl : wrPxl + 8'd1;
            if (wrValid & wrLineEnd) begin
                wrPxl   <= 8'd0;
                wrSlot  <= wrSlot + SLOT_BITS'(1);
                wrLines <= sat_inc(wrLines, MAX_LINES);
            end
            if (lineAdvance) rdLine <= sat_inc(rdLine, LAST_LINE);
            // slots are frozen for the whole burst; later rdLine moves don't retarget it
            if (start) begin
                srcSlot[0] <= prvSlot;
                srcSlot[1] <= rdLine[SLOT_BITS-1:0];
                srcSlot[2] <= nxtMissing ? rdLine[SLOT_BITS-1:0]
                                         : nxtLine[SLOT_BITS-1:0];
                if (nxtMissing) underrun <= 1'b1;
            end
            if (wrValid & busy & hitSrc) overrun <= 1'b1;
            if (nfRise) begin
                wrSlot   <= '0;
                wrPxl    <= 8'd0;
                wrLines  <= 8'd0;
                rdLine   <= 8'd0;
                underrun <= 1'b0;
            end
        end
    end

    line_fetch_fsm #(
        .PXLS (LINE_PXLS),
        .LAT  (RD_LAT)
    ) u_fetch (
        .pxlClk    (pxlClk),
        .rst       (rst),
        .start     (start),
        .abort     (nfRise),
        .stall     (wrValid),
        .rdEn      (rdEn),
        .rdSel     (rdSel),
        .rdPxl     (rdPxl),
        .busy      (busy),
        .fetchDone (fetchDone),
        .cacheWe   (cacheWe),
        .cacheSel  (cacheSel),
        .cacheAddr (cacheAddr)
    );

endmodule

// File: tb/tb_line_cache_sched.sv
// Randomized bench for line_cache_sched against a line-level model
// of the frame contents, the fetch timing and the sticky flags.
module tb_line_cache_sched;

    localparam int LP     = 240;
    localparam int FL     = 160;
    localparam int RD_LAT = 1;

    logic        pxlClk = 1'b0;
    logic        rst = 1'b1;
    logic        newFrameIn = 1'b0;
    logic        wrValid = 1'b0;
    logic [14:0] wrData = '0;
    logic        wrLineEnd = 1'b0;
    logic        lineAdvance = 1'b0;
    logic        fetchStart = 1'b0;
    logic        ramEn, ramWe;
    logic [9:0]  ramAddr;
    logic [14:0] ramWrData, ramRdData, cacheData;
    logic        cacheWe;
    logic [1:0]  cacheSel;
    logic [7:0]  cacheAddr, rdLine;
    logic        busy, fetchDone, overrun, underrun;

    always #5 pxlClk = ~pxlClk;

    line_cache_sched #(.RD_LAT(RD_LAT)) dut (
        .pxlClk      (pxlClk),
        .rst         (rst),
        .newFrameIn  (newFrameIn),
        .wrValid     (wrValid),
        .wrData      (wrData),
        .wrLineEnd   (wrLineEnd),
        .lineAdvance (lineAdvance),
        .fetchStart  (fetchStart),
        .ramEn       (ramEn),
        .ramWe       (ramWe),
        .ramAddr     (ramAddr),
        .ramWrData   (ramWrData),
        .ramRdData   (ramRdData),
        .cacheWe     (cacheWe),
        .cacheSel    (cacheSel),
        .cacheAddr   (cacheAddr),
        .cacheData   (cacheData),
        .busy        (busy),
        .fetchDone   (fetchDone),
        .overrun     (overrun),
        .underrun    (underrun),
        .rdLine      (rdLine)
    );

    logic [14:0] mem [1024];
    logic [14:0] rq [RD_LAT];

    always @(posedge pxlClk) begin
        if (ramEn && ramWe) mem[ramAddr] <= ramWrData;
        rq[0] <= mem[ramAddr];
        for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
    end
    assign ramRdData = rq[RD_LAT-1];

    int          weCnt = 0, doneCnt = 0, collide = 0;
    logic [14:0] capt [4][256];

    always @(negedge pxlClk) begin
        if (cacheWe) begin
            capt[cacheSel][cacheAddr] = cacheData;
            weCnt++;
        end
        if (fetchDone) doneCnt++;
        if (wrValid && !(ramEn && ramWe)) collide++;
    end

    int          checks = 0, errors = 0;
    int          wLine = 0, wPxl = 0, wDone = 0, rLine = 0;
    bit          expUnder = 0, expOvr = 0;
    logic [14:0] refPix [FL][LP];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pxlClk);
        #1;
    endtask

    task automatic drive_wr(input bit w);
        logic [14:0] d;
        wrValid   = w;
        wrLineEnd = 1'b0;
        if (w) begin
            d         = 15'($urandom);
            wrData    = d;
            wrLineEnd = (wPxl == LP - 1);
            if (wLine < FL) refPix[wLine][wPxl] = d;
            if (wPxl == LP - 1) begin
                wPxl = 0;
                wLine++;
                if (wDone < FL) wDone++;
            end else begin
                wPxl++;
            end
        end
    endtask

    task automatic write_lines(input int n);
        int left;
        left = n * LP;
        while (left > 0) begin
            if ($urandom_range(0, 7) == 0) drive_wr(0);
            else begin
                drive_wr(1);
                left--;
            end
            tick();
        end
        drive_wr(0);
    endtask

    task automatic new_frame();
        newFrameIn = 1'b1;
        tick();
        newFrameIn = 1'b0;
        tick();
        wLine = 0; wPxl = 0; wDone = 0; rLine = 0; expUnder = 0;
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            lineAdvance = 1'b1;
            tick();
            lineAdvance = 1'b0;
            if (rLine < FL - 1) rLine++;
        end
        tick();
    endtask

    task automatic run_fetch(input string tag, input int period,
                             input bit ovrTest);
        int srcL [3];
        int we0, dn0, col0, issued, expDone, gotDone, mism, phase;
        bit w;
        srcL[0] = (rLine == 0) ? 0 : rLine - 1;
        srcL[1] = rLine;
        srcL[2] = (rLine == FL - 1) ? rLine : rLine + 1;
        if (srcL[2] >= wDone) begin
            srcL[2]  = rLine;
            expUnder = 1;
        end
        we0 = weCnt; dn0 = doneCnt; col0 = collide;
        issued = 0; expDone = -1; gotDone = -1;
        phase = $urandom_range(0, 3);
        fetchStart = 1'b1;
        for (int n = 1; n <= 4000; n++) begin
            tick();
            fetchStart = 1'b0;
            if (fetchDone) begin
                gotDone = n;
                break;
            end
            w = (period != 0) && (n % period == phase)
              && (ovrTest || wPxl < LP - 1);
            if (w && (wLine % 4 == srcL[0] % 4 || wLine % 4 == srcL[1] % 4
                      || wLine % 4 == srcL[2] % 4))
                expOvr = 1;
            drive_wr(w);
            if (ovrTest && n == 100) fetchStart = 1'b1;
            if (issued < 3 * LP && !w) begin
                issued++;
                if (issued == 3 * LP) expDone = n + RD_LAT + 1;
            end
        end
        drive_wr(0);
        chk({tag, " len"}, gotDone, expDone);
        tick();
        chk({tag, " dones"}, doneCnt - dn0, 1);
        chk({tag, " pulse"}, int'(fetchDone), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " cwe"}, weCnt - we0, 3 * LP);
        chk({tag, " clash"}, collide - col0, 0);
        chk({tag, " under"}, int'(underrun), int'(expUnder));
        chk({tag, " over"}, int'(overrun), int'(expOvr));
        if (!ovrTest) begin
            mism = 0;
            for (int s = 0; s < 3; s++)
                for (int p = 0; p < LP; p++)
                    if (capt[s][p] !== refPix[srcL[s]][p]) mism++;
            chk({tag, " data"}, mism, 0);
        end
    endtask

    initial begin
        int dn0;
        repeat (3) tick();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(fetchDone), 0);
        chk("rst over", int'(overrun), 0);
        chk("rst under", int'(underrun), 0);
        chk("rst rdline", int'(rdLine), 0);
        chk("rst cwe", int'(cacheWe), 0);
        chk("rst ramen", int'(ramEn), 0);
        rst = 1'b0;
        tick();

        new_frame();
        write_lines(3);
        advance(1);
        chk("mid rdline", int'(rdLine), rLine);
        run_fetch("mid", 0, 0);
        run_fetch("stall", 4, 0);

        new_frame();
        write_lines(2);
        run_fetch("top", 0, 0);

        new_frame();
        write_lines(1);
        run_fetch("underrun", 0, 0);
        repeat (20) tick();
        chk("under hold", int'(underrun), 1);
        new_frame();
        chk("under clear", int'(underrun), 0);

        write_lines(3);
        advance(1);
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        repeat ($urandom_range(20, 600)) tick();
        chk("abort busy pre", int'(busy), 1);
        dn0 = doneCnt;
        newFrameIn = 1'b1;
        tick();
        newFrameIn = 1'b0;
        wLine = 0; wPxl = 0; wDone = 0; rLine = 0; expUnder = 0;
        chk("abort busy", int'(busy), 0);
        chk("abort rdline", int'(rdLine), 0);
        repeat (RD_LAT + 4) tick();
        chk("abort nodone", doneCnt - dn0, 0);
        drive_wr(1);
        #1;
        chk("abort waddr", int'(ramAddr), 0);
        tick();
        drive_wr(0);
        write_lines(3);
        advance(1);
        run_fetch("refetch", 0, 0);

        new_frame();
        write_lines(FL);
        advance(FL + 1);
        chk("bot rdline", int'(rdLine), rLine);
        run_fetch("bottom", 0, 0);

        new_frame();
        write_lines(4);
        advance(1);
        run_fetch("overrun", 4, 1);
        repeat (10) tick();
        chk("over hold", int'(overrun), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_cache_sched.md
Name: line_cache_sched

Overview:
Scheduler and arbiter for the single-port line RAM that sits between GBA pixel capture and the HDMI image generator.
- Owns a ring of 4 GBA line slots and writes incoming GBA pixels into it.
- On each cacheUpdate pulse from the image generator, fetches the prev/cur/next line triplet into the three small neighbourhood line caches that feed grid, smoothing and plain output.
- Shares the RAM port between the real-time writer, which always wins, and the burst reader.

Parameters:
LINE_PXLS, 240, pixels per GBA line
FRAME_LINES, 160, GBA lines per frame
SLOT_BITS, 2, log2 of ring depth (4 slots)
PXL_W, 15, stored pixel width (GBA RGB555)
RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
pxlClk  in  1  clock
rst  in  1  reset
newFrameIn  in  1  GBA frame start pulse (pxlClk domain)
wrValid  in  1  GBA pixel strobe
wrData  in  PXL_W  GBA pixel
wrLineEnd  in  1  last pixel of a GBA line (qualified by wrValid)
lineAdvance  in  1  image generator nextLine pulse
fetchStart  in  1  image generator cacheUpdate pulse
ramEn  out  1  RAM enable
ramWe  out  1  RAM write enable
ramAddr  out  SLOT_BITS+8  {slot, pixel}
ramWrData  out  PXL_W  RAM write data
ramRdData  in  PXL_W  RAM read data, RD_LAT after ramEn&!ramWe
cacheWe  out  1  line-cache write strobe
cacheSel  out  2  0=prev, 1=cur, 2=next
cacheAddr  out  8  line-cache pixel index
cacheData  out  PXL_W  line-cache write data
busy  out  1  fetch in progress
fetchDone  out  1  one-cycle pulse when the triplet is complete
overrun  out  1  sticky: writer entered the slot being read
underrun  out  1  sticky: next line not yet written at fetch
rdLine  out  8  GBA line currently presented as "cur"

Behaviour:
- Reset: rst is synchronous and active-high, clocked on pxlClk. All outputs, counters and flags clear to 0; FSM goes to IDLE.
- Writer:
  - wrValid: ramEn=ramWe=1, ramAddr={wrSlot, wrPxl}, wrPxl++.
  - wrLineEnd: wrPxl=0, wrSlot++ (mod 4), wrLines++ (saturates at FRAME_LINES).
  - newFrameIn rising edge: wrSlot=wrPxl=wrLines=0, rdLine=0. Any in-progress fetch is aborted to IDLE with no fetchDone.
- lineAdvance: rdLine++ (saturates at FRAME_LINES-1). The slot for "cur" is rdLine mod 4.
- Source line per cacheSel:
  - prev = max(rdLine-1, 0)
  - cur = rdLine
  - next = min(rdLine+1, FRAME_LINES-1)
  - Top and bottom edges therefore clamp to cur.
  - If next >= wrLines, cur is used as next and underrun is set (sticky until newFrameIn).
- FSM: IDLE -> FETCH_PREV -> FETCH_CUR -> FETCH_NEXT -> DRAIN -> IDLE.
  - fetchStart in IDLE: busy=1, rdPxl=0, enter FETCH_PREV.
  - Each FETCH state issues LINE_PXLS reads, rdPxl 0..239.
  - A read is issued only on cycles with wrValid=0. The writer has absolute priority and the read address is held while stalled.
  - After rdPxl=239 is issued, advance to the next state with rdPxl=0.
  - DRAIN waits RD_LAT cycles for in-flight reads, then pulses fetchDone for 1 cycle; busy drops the same cycle.
- Read return pipeline: a RD_LAT-deep shift register of {valid, sel, addr}. cacheWe/cacheSel/cacheAddr/cacheData are asserted exactly RD_LAT cycles after issue, with cacheData=ramRdData.
- fetchStart while busy: ignored; no restart, no flag.
- Overrun: set when a write targets the slot of any line in the active triplet during a fetch. The write still proceeds; no reads are re-issued.
- lineAdvance during a fetch: rdLine updates immediately, but the in-flight fetch keeps the source slots latched at fetchStart.
- Arithmetic: slots wrap mod 2^SLOT_BITS; pixel counters are 8 bit and never exceed LINE_PXLS-1.
- Worst-case fetch is 3*240 + RD_LAT cycles plus write stalls, which must fit in one HDMI line (1650 cycles at 720p).

Decomposition:
- definePackage gains LINE_PXLS, FRAME_LINES, SLOT_BITS and GBA_PXL_W constants, plus typedef cache_sel_t (enum PREV/CUR/NEXT) shared with imageGenV.
- One sub-module: line_fetch_fsm. It holds the FSM, rdPxl counter and return pipeline. The parent keeps the writer, arbitration and flags.

Test Plan:
- Write 3 lines (values = line*256 + pxl), rdLine=1, fetchStart -> 720 cacheWe, sel 0/1/2 carrying lines 0/1/2; fetchDone after exactly 720+RD_LAT+1 cycles; underrun=0.
- Same as above with wrValid every 4th cycle during the fetch -> no ramWe/read collision; fetch length = 720 + number of stall cycles; cache contents identical.
- rdLine=0 -> prev data equals line 0; rdLine=159 -> next equals line 159; no underrun at either.
- fetchStart with wrLines=1 and rdLine=0 -> next equals line 0, underrun=1, held until newFrameIn.
- newFrameIn mid-fetch -> busy=0 next cycle, no fetchDone, counters=0; a following fetchStart fetches correctly.
- Writer wraps 4 slots while reading line 1 -> overrun=1 (sticky); a second fetchStart while busy is ignored.
